mutex_merge_arbiter: RTL and testbench

Clocked N-way round-robin arbiter that owns a shared drive/free handshake channel feeding a mutex-merge stage. It serializes requesters so at most one drive is ever in flight downstream, which guarantees the mutual-exclusion precondition the merge relies on. The arbiter returns each free to the requester that owns the grant, and watches the channel for lost or spurious frees. It sits between the synchronous control logic and the merge input of the RCA datapath.

---
 rtl/mutex_merge_arbiter.sv | 117 +++++++++++
 tb/tb_mutex_merge_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mutex_merge_arbiter.sv
// Round-robin arbiter owning a single drive/free channel into a mutex-merge stage.
// Serializes requesters so at most one drive is in flight, with a WAIT watchdog and spurious-free detection.
module mutex_merge_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned TIMEOUT = 200,
  parameter int unsigned IDW     = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   i_req,
  output logic [N-1:0]   o_grant,
  output logic           o_driveNext,
  input  logic           i_freeNext,
  output logic [N-1:0]   o_free,
  output logic           o_busy,
  output logic [IDW-1:0] o_last_id,
  output logic [1:0]     o_err
);

  localparam int unsigned WDW = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT,
    S_RELEASE
  } state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [WDW-1:0] wdog;
  logic [IDW-1:0] pick_idx;
  logic           pick_vld;

  // Index arithmetic modulo N for the rotating priority pointer.
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= N) s = s - N;
    return IDW'(s);
  endfunction

  // First requester at or above rr_ptr; scanning farthest-first lets the nearest win.
  always_comb begin
    logic [IDW-1:0] cand;
    pick_idx = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = wrap_add(rr_ptr, N - 1 - k);
      if (i_req[cand]) begin
        pick_idx = cand;
        pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      wdog        <= '0;
      o_grant     <= '0;
      o_driveNext <= 1'b0;
      o_free      <= '0;
      o_busy      <= 1'b0;
      o_last_id   <= '0;
      o_err       <= '0;
    end else begin
      // A free outside WAIT never belongs to an in-flight drive.
      if (i_freeNext && (state != S_WAIT)) o_err[1] <= 1'b1;

      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            o_grant     <= N'(1) << pick_idx;
            o_last_id   <= pick_idx;
            o_driveNext <= 1'b1;
            o_busy      <= 1'b1;
            state       <= S_DRIVE;
          end
        end

        S_DRIVE: begin
          o_driveNext <= 1'b0;
          wdog        <= '0;
          state       <= S_WAIT;
        end

        S_WAIT: begin
          if (i_freeNext) begin
            o_free <= o_grant;
            state  <= S_RELEASE;
          end else if (wdog == WDW'(TIMEOUT - 1)) begin
            // Abort still releases the owner so it is never left blocked.
            o_err[0] <= 1'b1;
            o_free   <= o_grant;
            state    <= S_RELEASE;
          end else begin
            wdog <= wdog + WDW'(1);
          end
        end

        S_RELEASE: begin
          o_free  <= '0;
          o_grant <= '0;
          o_busy  <= 1'b0;
          rr_ptr  <= wrap_add(o_last_id, 1);
          state   <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mutex_merge_arbiter.sv
// Bench for mutex_merge_arbiter: transaction-timeline reference model feeding an expected-event queue,
// with a monitor that checks every cycle's outputs against it.
module tb_mutex_merge_arbiter;

  localparam int unsigned N       = 4;
  localparam int unsigned TIMEOUT = 5;
  localparam int unsigned IDW     = 2;
  localparam int          INF     = 32'h3fff_ffff;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   i_req;
  logic [N-1:0]   o_grant;
  logic           o_driveNext;
  logic           i_freeNext;
  logic [N-1:0]   o_free;
  logic           o_busy;
  logic [IDW-1:0] o_last_id;
  logic [1:0]     o_err;

  mutex_merge_arbiter #(.N(N), .TIMEOUT(TIMEOUT), .IDW(IDW)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req       (i_req),
    .o_grant     (o_grant),
    .o_driveNext (o_driveNext),
    .i_freeNext  (i_freeNext),
    .o_free      (o_free),
    .o_busy      (o_busy),
    .o_last_id   (o_last_id),
    .o_err       (o_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           at;
    bit           is_drive;
    logic [N-1:0] val;
  } ev_t;

  ev_t exp_q[$];

  // Reference timeline of the current/last transaction (cycle stamps).
  int idle_at = 0, drv_c = 0, wait_last = -1, free_at = -1, rel_c = -1;
  int owner = 0, rr = 0;
  int busy_from = INF, busy_to = -1;
  int err0_from = INF, err1_from = INF;
  int lid_prev = 0, lid_new = 0, lid_from = 0;
  logic [N-1:0] req = '0;

  // Stimulus knobs.
  int unsigned raise_pct = 0, spur_pm = 0, rst_pm = 0, drop_pm = 0;
  int unsigned d_lo = 0, d_hi = 0;
  bit force_rst = 1'b0;
  int last_c = 0;

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: pops expected events when due and checks all outputs each cycle.
  logic         m_drv, m_busy;
  logic [N-1:0] m_free, m_grant;
  logic [1:0]   m_err;
  int           m_lid;
  initial forever begin
    @(negedge clk);
    while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL missed_event cyc=%0d got=none expected=%s at %0d", cyc,
               exp_q[0].is_drive ? "drive" : "free", exp_q[0].at);
      void'(exp_q.pop_front());
    end
    m_drv  = 1'b0;
    m_free = '0;
    if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
      if (exp_q[0].is_drive) m_drv = 1'b1;
      else m_free = exp_q[0].val;
      void'(exp_q.pop_front());
    end
    if (o_driveNext !== 1'b0 || m_drv) check("drive", 32'(o_driveNext), 32'(m_drv));
    if (o_free !== '0 || m_free != '0) check("free", 32'(o_free), 32'(m_free));
    m_busy  = (cyc >= busy_from) && (cyc <= busy_to);
    m_grant = '0;
    if (m_busy) m_grant[IDW'(owner)] = 1'b1;
    m_lid = (cyc >= lid_from) ? lid_new : lid_prev;
    m_err = {cyc >= err1_from, cyc >= err0_from};
    check("busy", 32'(o_busy), 32'(m_busy));
    check("grant", 32'(o_grant), 32'(m_grant));
    check("last_id", 32'(o_last_id), 32'(m_lid));
    check("err", 32'(o_err), 32'(m_err));
  end

  // One driver cycle: update the model, then drive inputs sampled at the next edge.
  task automatic step();
    int  c, pick, d;
    bit  do_rst, found, fn;
    logic [N-1:0] oh;
    @(negedge clk);
    #1;
    c = cyc;
    last_c = c;

    do_rst = force_rst || (rst_pm != 0 && $urandom_range(999) < rst_pm);
    force_rst = 1'b0;
    if (do_rst) begin
      idle_at = c + 1;
      rr = 0;
      if (busy_to > c) busy_to = c;
      rel_c = -1;
      free_at = -1;
      wait_last = -1;
      lid_prev = 0;
      lid_new = 0;
      lid_from = 0;
      err0_from = INF;
      err1_from = INF;
      while (exp_q.size() > 0 && exp_q[$].at > c) void'(exp_q.pop_back());
    end

    if (c == rel_c) req[IDW'(owner)] = 1'b0;
    else if (c >= drv_c && c < rel_c && drop_pm != 0 && $urandom_range(999) < drop_pm)
      req[IDW'(owner)] = 1'b0;
    for (int i = 0; i < int'(N); i++)
      if (!req[IDW'(i)] && !(i == owner && c <= rel_c) && $urandom_range(99) < raise_pct)
        req[IDW'(i)] = 1'b1;

    if (!do_rst && c >= idle_at && req != '0) begin
      found = 1'b0;
      pick = 0;
      for (int k = 0; k < int'(N); k++) begin
        if (!found && req[IDW'((rr + k) % int'(N))]) begin
          pick = (rr + k) % int'(N);
          found = 1'b1;
        end
      end
      owner = pick;
      drv_c = c + 1;
      d = int'($urandom_range(d_hi, d_lo));
      if (d < int'(TIMEOUT)) begin
        free_at = drv_c + 1 + d;
        wait_last = free_at;
        rel_c = free_at + 1;
      end else begin
        free_at = -1;
        wait_last = drv_c + int'(TIMEOUT);
        rel_c = wait_last + 1;
        if (err0_from > rel_c) err0_from = rel_c;
      end
      idle_at = rel_c + 1;
      rr = (pick + 1) % int'(N);
      busy_from = drv_c;
      busy_to = rel_c;
      lid_prev = lid_new;
      lid_new = pick;
      lid_from = drv_c;
      oh = '0;
      oh[IDW'(pick)] = 1'b1;
      exp_q.push_back('{at: drv_c, is_drive: 1'b1, val: oh});
      exp_q.push_back('{at: rel_c, is_drive: 1'b0, val: oh});
    end

    fn = 1'b0;
    if (!do_rst && c == free_at) fn = 1'b1;
    else if (!do_rst && !(c >= drv_c + 1 && c <= wait_last) && spur_pm != 0 &&
             $urandom_range(999) < spur_pm) begin
      fn = 1'b1;
      if (err1_from > c + 1) err1_from = c + 1;
    end

    rst = do_rst;
    i_req = req;
    i_freeNext = fn;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b1;
    i_req = '0;
    i_freeNext = 1'b0;

    force_rst = 1'b1; step();
    force_rst = 1'b1; step();

    // Single request from requester 1, free on the second WAIT cycle.
    d_lo = 1; d_hi = 1;
    req[1] = 1'b1;
    run(8);

    // All requesters continuously, free on the first WAIT cycle.
    raise_pct = 100; d_lo = 0; d_hi = 0;
    run(40);
    raise_pct = 0;
    run(20);

    // Watchdog abort, then clean transactions keep the sticky bit.
    d_lo = TIMEOUT + 2; d_hi = TIMEOUT + 2;
    req[2] = 1'b1;
    run(15);
    raise_pct = 30; d_lo = 0; d_hi = 3;
    run(40);
    raise_pct = 0;
    run(20);

    // Spurious free while idle.
    spur_pm = 1000;
    step();
    spur_pm = 0;
    run(4);

    // Reset in WAIT, then a new request set is arbitrated from index 0.
    d_lo = 3; d_hi = 3;
    req[3] = 1'b1;
    for (int k = 0; k < 20 && last_c != drv_c + 1; k++) step();
    force_rst = 1'b1;
    step();
    req[1] = 1'b1;
    run(20);

    // Randomized traffic with drops, spurious frees, aborts and resets.
    raise_pct = 25; d_lo = 0; d_hi = TIMEOUT + 1;
    spur_pm = 15; rst_pm = 3; drop_pm = 50;
    run(3000);
    raise_pct = 0; spur_pm = 0; rst_pm = 0; drop_pm = 0;
    run(80);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain cyc=%0d got=%0d pending expected=0 pending", cyc, exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule
